vanilla_trace_arbiter: RTL and testbench



---
 rtl/vanilla_trace_arbiter_if.sv | 32 +++
 rtl/vanilla_trace_arbiter.sv | 135 +++++++++++++
 tb/tb_vanilla_trace_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vanilla_trace_arbiter_if.sv
// Trace arbiter bus: per-core record inputs, merged output stream, drop counts.
// The slave modport is the arbiter side; the master modport is the core/consumer side.
interface vanilla_trace_arbiter_if #(
  parameter int num_req_p        = 4,
  parameter int rec_width_p      = 128,
  parameter int drop_cnt_width_p = 16
);
  localparam int id_width_lp = $clog2(num_req_p);

  logic                                   trace_en_i;
  logic [num_req_p-1:0]                   v_i;
  logic [num_req_p*rec_width_p-1:0]       data_i;
  // Output handshake: a record transfers in a cycle with v_o=1 and yumi_i=1;
  // yumi_i is only raised while v_o=1, and data_o/id_o hold still until then.
  logic                                   v_o;
  logic [rec_width_p-1:0]                 data_o;
  logic [id_width_lp-1:0]                 id_o;
  logic                                   yumi_i;
  logic [num_req_p*drop_cnt_width_p-1:0]  drop_cnt_o;
  logic                                   idle_o;
  logic [1:0]                             state_o;

  modport slave (
    input  trace_en_i, v_i, data_i, yumi_i,
    output v_o, data_o, id_o, drop_cnt_o, idle_o, state_o
  );

  modport master (
    output trace_en_i, v_i, data_i, yumi_i,
    input  v_o, data_o, id_o, drop_cnt_o, idle_o, state_o
  );
endinterface

// File: rtl/vanilla_trace_arbiter.sv
// Round-robin merge of per-core trace records through one-entry holding registers.
// Optional VANILLA_TRACE_ARB_DROP_CNT_EN builds the per-requester drop counters.
module vanilla_trace_arbiter #(
  parameter int num_req_p        = 4,
  parameter int rec_width_p      = 128,
  parameter int drop_cnt_width_p = 16
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  vanilla_trace_arbiter_if.slave bus
);
  localparam int id_width_lp = $clog2(num_req_p);

  typedef enum logic [1:0] {
    off_s   = 2'd0,
    run_s   = 2'd1,
    drain_s = 2'd2
  } state_e;

  state_e                   state_r;
  logic [num_req_p-1:0]     hold_v_r;
  logic [rec_width_p-1:0]   hold_data_r [num_req_p];
  logic                     out_v_r;
  logic [rec_width_p-1:0]   out_data_r;
  logic [id_width_lp-1:0]   out_id_r;
  logic [id_width_lp-1:0]   ptr_r;

  logic                     gnt_v;
  logic [id_width_lp-1:0]   gnt_id;
  logic [num_req_p-1:0]     gnt_oh;
  logic [num_req_p-1:0]     cap;
  logic                     running;

  assign running = (state_r == run_s);

  // First full holding register at or after ptr_r, wrapping.
  always_comb begin : arb_search
    int idx;
    idx    = 0;
    gnt_v  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!gnt_v && hold_v_r[idx[id_width_lp-1:0]]) begin
        gnt_v  = 1'b1;
        gnt_id = idx[id_width_lp-1:0];
      end
    end
    if (out_v_r && !bus.yumi_i) gnt_v = 1'b0;
  end

  always_comb begin
    gnt_oh = '0;
    cap    = '0;
    for (int i = 0; i < num_req_p; i++) begin
      gnt_oh[i] = gnt_v && (gnt_id == id_width_lp'(i));
      cap[i]    = bus.v_i[i] && running && (!hold_v_r[i] || gnt_oh[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= off_s;
      hold_v_r   <= '0;
      ptr_r      <= '0;
      out_v_r    <= 1'b0;
      out_data_r <= '0;
      out_id_r   <= '0;
    end else begin
      hold_v_r <= (hold_v_r & ~gnt_oh) | cap;

      if (gnt_v) begin
        out_v_r    <= 1'b1;
        out_data_r <= hold_data_r[gnt_id];
        out_id_r   <= gnt_id;
        ptr_r      <= (gnt_id == id_width_lp'(num_req_p - 1)) ? '0
                                                              : gnt_id + id_width_lp'(1);
      end else if (bus.yumi_i) begin
        out_v_r <= 1'b0;
      end

      case (state_r)
        off_s:   if (bus.trace_en_i) state_r <= run_s;
        run_s:   if (!bus.trace_en_i) state_r <= drain_s;
        drain_s: begin
          if (bus.trace_en_i)                 state_r <= run_s;
          else if (!(|hold_v_r) && !out_v_r)  state_r <= off_s;
        end
        default: state_r <= off_s;
      endcase
    end
  end

  // Payload only matters while its valid bit is set, so it carries no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_req_p; i++) begin
      if (cap[i]) hold_data_r[i] <= bus.data_i[i*rec_width_p +: rec_width_p];
    end
  end

`ifdef VANILLA_TRACE_ARB_DROP_CNT_EN
  logic [num_req_p-1:0]        drop;
  logic [drop_cnt_width_p-1:0] drop_cnt_r [num_req_p];

  always_comb begin
    drop = '0;
    for (int i = 0; i < num_req_p; i++) begin
      drop[i] = bus.v_i[i] && running && hold_v_r[i] && !gnt_oh[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_req_p; i++) begin
      if (!reset_n_i)                           drop_cnt_r[i] <= '0;
      else if (drop[i] && (drop_cnt_r[i] != '1)) drop_cnt_r[i] <= drop_cnt_r[i] + 1'b1;
    end
  end

  always_comb begin
    bus.drop_cnt_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      bus.drop_cnt_o[i*drop_cnt_width_p +: drop_cnt_width_p] = drop_cnt_r[i];
    end
  end
`else
  assign bus.drop_cnt_o = {(num_req_p*drop_cnt_width_p){1'b0}};
`endif

  assign bus.v_o     = out_v_r;
  assign bus.data_o  = out_data_r;
  assign bus.id_o    = out_id_r;
  assign bus.idle_o  = (state_r == off_s) && !(|hold_v_r) && !out_v_r;
  assign bus.state_o = state_r;
endmodule

// File: tb/tb_vanilla_trace_arbiter.sv
// Bench for vanilla_trace_arbiter: directed table, corner sequences, random run
// against a transaction-level model; drop expectations follow VANILLA_TRACE_ARB_DROP_CNT_EN.
module tb_vanilla_trace_arbiter;
  localparam int N       = 4;
  localparam int RW      = 16;
  localparam int DW      = 4;
  localparam int IDW     = 2;
  localparam int W       = RW + IDW;
  localparam int CNT_MAX = (1 << DW) - 1;
`ifdef VANILLA_TRACE_ARB_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int M_OFF = 0, M_RUN = 1, M_DRAIN = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vanilla_trace_arbiter_if #(.num_req_p(N), .rec_width_p(RW), .drop_cnt_width_p(DW)) bus ();

  vanilla_trace_arbiter #(.num_req_p(N), .rec_width_p(RW), .drop_cnt_width_p(DW)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  int          m_mode;
  bit          m_slot_v [N];
  logic [RW-1:0] m_slot_d [N];
  bit          m_out_v;
  int          m_ptr;
  int          m_drops [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int i);
    int c;
    c = (m_drops[i] > CNT_MAX) ? CNT_MAX : m_drops[i];
    return CNT_EN ? c : 0;
  endfunction

  function automatic bit m_idle();
    bit any;
    any = m_out_v;
    for (int i = 0; i < N; i++) any |= m_slot_v[i];
    return (m_mode == M_OFF) && !any;
  endfunction

  task automatic model_reset();
    m_mode  = M_OFF;
    m_out_v = 1'b0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      m_slot_v[i] = 1'b0;
      m_slot_d[i] = '0;
      m_drops[i]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic reset_dut(input int cycles);
    reset_n        = 1'b0;
    bus.trace_en_i = 1'b0;
    bus.v_i        = '0;
    bus.yumi_i     = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic check_drop_cnts();
    for (int i = 0; i < N; i++)
      chk($sformatf("drop_cnt[%0d]", i), bus.drop_cnt_o[i*DW +: DW], exp_cnt(i));
  endtask

  // ---------------- driver: one cycle, with model step ----------------
  task automatic tick(input bit en, input logic [N-1:0] v, input bit yumi);
    bit y, was_empty, run;
    int win, j;
    logic [W-1:0] rec;
    bus.trace_en_i = en;
    bus.v_i        = v;
    y              = yumi && m_out_v;
    bus.yumi_i     = y;

    chk("v_o", bus.v_o, m_out_v);
    chk("idle_o", bus.idle_o, m_idle());
    check_drop_cnts();
    if (y && bus.v_o) begin
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        rec = exp_q.pop_front();
        chk("sb_record", {bus.data_o, bus.id_o}, rec);
      end
    end

    was_empty = !m_out_v;
    for (int i = 0; i < N; i++) if (m_slot_v[i]) was_empty = 1'b0;
    run = (m_mode == M_RUN);

    win = -1;
    if (!m_out_v || y) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && m_slot_v[j]) win = j;
      end
    end
    if (win >= 0) begin
      m_out_v = 1'b1;
      exp_q.push_back({m_slot_d[win], IDW'(win)});
      m_slot_v[win] = 1'b0;
      m_ptr = (win + 1) % N;
    end else if (y) begin
      m_out_v = 1'b0;
    end

    if (run) begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          if (m_slot_v[i]) m_drops[i]++;
          else begin
            m_slot_v[i] = 1'b1;
            m_slot_d[i] = bus.data_i[i*RW +: RW];
          end
        end
      end
    end

    case (m_mode)
      M_OFF:   if (en) m_mode = M_RUN;
      M_RUN:   if (!en) m_mode = M_DRAIN;
      default: if (en) m_mode = M_RUN; else if (was_empty) m_mode = M_OFF;
    endcase

    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit            en;
    logic [N-1:0]  v;
    bit            yumi;
    logic [RW-1:0] base;
    bit            exp_v;
    logic [IDW-1:0] exp_id;
    logic [RW-1:0] exp_d;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int exp_ids [3];
    int budget;
    bit en_r;

    tbl[0]  = '{1'b1, 4'b0001, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000};
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 16'h0010, 1'b0, 2'd0, 16'h0000};
    tbl[2]  = '{1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000};
    tbl[3]  = '{1'b1, 4'b0000, 1'b1, 16'h0000, 1'b1, 2'd0, 16'h0010};
    tbl[4]  = '{1'b1, 4'b0000, 1'b1, 16'h0000, 1'b1, 2'd1, 16'h0011};
    tbl[5]  = '{1'b1, 4'b0000, 1'b1, 16'h0000, 1'b1, 2'd2, 16'h0012};
    tbl[6]  = '{1'b1, 4'b0000, 1'b1, 16'h0000, 1'b1, 2'd3, 16'h0013};
    tbl[7]  = '{1'b1, 4'b1111, 1'b0, 16'h0020, 1'b0, 2'd0, 16'h0000};
    tbl[8]  = '{1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000};
    tbl[9]  = '{1'b1, 4'b0000, 1'b1, 16'h0000, 1'b1, 2'd0, 16'h0020};
    tbl[10] = '{1'b1, 4'b0000, 1'b1, 16'h0000, 1'b1, 2'd1, 16'h0021};
    tbl[11] = '{1'b1, 4'b0000, 1'b1, 16'h0000, 1'b1, 2'd2, 16'h0022};
    tbl[12] = '{1'b1, 4'b0000, 1'b1, 16'h0000, 1'b1, 2'd3, 16'h0023};
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000};

    bus.data_i = '0;
    reset_dut(2);
    chk("rst_v_o", bus.v_o, 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_id_o", bus.id_o, 0);
    chk("rst_idle_o", bus.idle_o, 1);
    chk("rst_drop_cnt", bus.drop_cnt_o, 0);

    // Round robin, two bursts from ptr=0; row 0 also shows v_i ignored in OFF.
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < N; i++) bus.data_i[i*RW +: RW] = tbl[r].base + RW'(i);
      chk("rr_v", bus.v_o, tbl[r].exp_v);
      if (tbl[r].exp_v) begin
        chk("rr_id", bus.id_o, tbl[r].exp_id);
        chk("rr_data", bus.data_o, tbl[r].exp_d);
      end
      tick(tbl[r].en, tbl[r].v, tbl[r].yumi);
    end

    // Single record: 2-cycle latency, held stable while yumi_i=0.
    bus.data_i = '0;
    bus.data_i[2*RW +: RW] = 16'h00A5;
    tick(1'b1, 4'b0100, 1'b0);
    tick(1'b1, 4'b0000, 1'b0);
    chk("single_v", bus.v_o, 1);
    chk("single_data", bus.data_o, 16'h00A5);
    chk("single_id", bus.id_o, 2);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 4'b0000, 1'b0);
      chk("hold_v", bus.v_o, 1);
      chk("hold_data", bus.data_o, 16'h00A5);
      chk("hold_id", bus.id_o, 2);
    end
    tick(1'b1, 4'b0000, 1'b1);
    tick(1'b1, 4'b0000, 1'b0);

    // Drops on requester 1 and saturation on requester 0 behind a stalled output.
    bus.data_i[1*RW +: RW] = 16'h0031;
    tick(1'b1, 4'b0010, 1'b0);
    tick(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.data_i[1*RW +: RW] = 16'h0032 + RW'(k);
      tick(1'b1, 4'b0010, 1'b0);
    end
    bus.data_i[0 +: RW] = 16'h0040;
    repeat (21) tick(1'b1, 4'b0001, 1'b0);
    tick(1'b1, 4'b0000, 1'b0);
    chk("drop_cnt1", bus.drop_cnt_o[1*DW +: DW], CNT_EN ? 2 : 0);
    chk("drop_sat0", bus.drop_cnt_o[0 +: DW], CNT_EN ? 15 : 0);
    chk("drop_out0", {bus.data_o, bus.id_o}, {16'h0031, 2'd1});
    tick(1'b1, 4'b0000, 1'b1);
    chk("drop_out1", {bus.data_o, bus.id_o}, {16'h0040, 2'd0});
    tick(1'b1, 4'b0000, 1'b1);
    chk("drop_retained", {bus.data_o, bus.id_o}, {16'h0032, 2'd1});
    tick(1'b1, 4'b0000, 1'b1);
    chk("drop_empty", bus.v_o, 0);

    // Drain: three records buffered, inputs during DRAIN ignored.
    for (int i = 0; i < 3; i++) bus.data_i[i*RW +: RW] = 16'h0050 + RW'(i);
    tick(1'b1, 4'b0111, 1'b0);
    tick(1'b1, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    bus.data_i[1*RW +: RW] = 16'h005E;
    bus.data_i[3*RW +: RW] = 16'h005F;
    tick(1'b0, 4'b1010, 1'b0);
    chk("drain_no_drop", bus.drop_cnt_o[1*DW +: DW], CNT_EN ? 2 : 0);
    exp_ids[0] = 2; exp_ids[1] = 0; exp_ids[2] = 1;
    for (int k = 0; k < 3; k++) begin
      chk("drain_v", bus.v_o, 1);
      chk("drain_id", bus.id_o, exp_ids[k]);
      chk("drain_data", bus.data_o, 16'h0050 + exp_ids[k]);
      tick(1'b0, 4'b0000, 1'b1);
    end
    budget = 5;
    while (!bus.idle_o && budget > 0) begin
      tick(1'b0, 4'b0000, 1'b0);
      budget--;
    end
    chk("drain_idle", bus.idle_o, 1);
    chk("drain_empty", bus.v_o, 0);

    // Randomized traffic against the model.
    en_r = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) en_r = ~en_r;
      for (int i = 0; i < N; i++) bus.data_i[i*RW +: RW] = RW'($urandom);
      tick(en_r, N'($urandom_range(0, (1 << N) - 1)) & N'($urandom_range(0, (1 << N) - 1)),
           $urandom_range(0, 3) != 0);
    end
    budget = 50;
    while (!bus.idle_o && budget > 0) begin
      tick(1'b0, 4'b0000, 1'b1);
      budget--;
    end
    chk("rand_final_idle", bus.idle_o, 1);
    chk("rand_sb_empty", exp_q.size(), 0);

    // Reset mid-stream while v_o=1.
    tick(1'b1, 4'b0000, 1'b0);
    bus.data_i[0 +: RW] = 16'h0077;
    tick(1'b1, 4'b0001, 1'b0);
    tick(1'b1, 4'b0011, 1'b0);
    chk("rst_mid_pre_v", bus.v_o, 1);
    reset_n    = 1'b0;
    bus.v_i    = '0;
    bus.yumi_i = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    chk("rst_mid_v", bus.v_o, 0);
    chk("rst_mid_drop", bus.drop_cnt_o, 0);
    chk("rst_mid_idle", bus.idle_o, 1);
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
